// File: rtl/mem_pkg.sv
// Shared types and constants for the vector-capable memory stage.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int VEC_W  = 128;
  localparam int LANES  = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    VRD,
    VLAST,
    VWR,
    RESP
  } mem_state_t;

  // Select 32-bit lane idx out of a 128-bit vector.
  function automatic logic [WORD_W-1:0] lane_sel(input logic [VEC_W-1:0] vec,
                                                 input logic [1:0]       idx);
    return vec[{idx, 5'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/vlsu_lane_buf.sv
// Vector load capture register with per-lane write enable, plus the lane
// mux that feeds vector store data to the memory one word per beat.
module vlsu_lane_buf
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [1:0]        cap_idx,
  input  logic [WORD_W-1:0] cap_data,
  input  logic [VEC_W-1:0]  st_vec,
  input  logic [1:0]        st_idx,
  output logic [WORD_W-1:0] st_lane,
  output logic [VEC_W-1:0]  vec_out
);

  logic [VEC_W-1:0] buf_d, buf_q;

  // Overwrite only the addressed lane; other lanes keep their old contents.
  always_comb begin
    buf_d = buf_q;
    if (cap_en) begin
      buf_d[{cap_idx, 5'd0} +: WORD_W] = cap_data;
    end
  end

  // Capture register.
  always_ff @(posedge clk) begin
    // NOTE: this is a small register bank, not a RAM macro, so it is safe to
    // reset; a real memory array would be left unreset.
    if (rst) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign st_lane = lane_sel(st_vec, st_idx);
  assign vec_out = buf_q;

endmodule

// File: rtl/mem_stage_vlsu.sv
// Memory stage: scalar word and 4-beat vector loads/stores against a 32-bit
// synchronous data memory, stalling upstream until each access completes.
module mem_stage_vlsu
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              VecMem,
  input  logic [31:0]       ALUresult,
  input  logic [WORD_W-1:0] WriteData,
  input  logic [VEC_W-1:0]  VWriteData,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] ReadData,
  output logic [VEC_W-1:0]  VReadData,
  output logic              done,
  output logic              stall,
  output logic              align_err
);

  localparam logic [1:0] LAST_BEAT = 2'(LANES - 1);

  mem_state_t        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              req;
  logic [ADDR_W-1:0] wa;
  logic [1:0]        beat;
  logic [1:0]        cap_idx;
  logic              issue;
  logic              we;
  logic              cap_en;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] st_lane;
  logic              unused_addr_bits;

  assign req     = MemRead | MemWrite;
  assign wa      = ALUresult[ADDR_W+1:2];
  // IDLE always issues beat 0; otherwise the counter is the lane index.
  assign beat    = (state_q == IDLE) ? 2'd0 : cnt_q;
  // Read data lags the issued address by one cycle, so capture trails by one.
  assign cap_idx = cnt_q - 2'd1;
  assign unused_addr_bits = ^ALUresult[31:ADDR_W+2];

  // Next-state, beat sequencing and memory-port control.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    issue   = 1'b0;
    we      = 1'b0;
    cap_en  = 1'b0;
    wdata   = '0;
    done    = 1'b0;
    stall   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        if (req) begin
          issue = 1'b1;
          stall = 1'b1;
          if (MemWrite) begin
            // A store wins when both requests are raised.
            we = 1'b1;
            if (VecMem) begin
              wdata   = st_lane;
              cnt_d   = 2'd1;
              state_d = VWR;
            end else begin
              wdata = WriteData;
              done  = 1'b1;
              stall = 1'b0;
            end
          end else if (VecMem) begin
            cnt_d   = 2'd1;
            state_d = VRD;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        stall   = 1'b1;
        rdata_d = mem_rdata;
        state_d = RESP;
      end
      VRD: begin
        stall  = 1'b1;
        issue  = 1'b1;
        cap_en = 1'b1;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == LAST_BEAT) begin
          state_d = VLAST;
        end
      end
      VLAST: begin
        stall   = 1'b1;
        cap_en  = 1'b1;
        state_d = RESP;
      end
      VWR: begin
        issue = 1'b1;
        we    = 1'b1;
        wdata = st_lane;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_BEAT) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      RESP: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset abandons the access at once: no write, no handshake.
    if (rst) begin
      issue  = 1'b0;
      we     = 1'b0;
      cap_en = 1'b0;
      wdata  = '0;
      done   = 1'b0;
      stall  = 1'b0;
    end
  end

  // State, beat counter and scalar load result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  vlsu_lane_buf u_lane_buf (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cap_en),
    .cap_idx  (cap_idx),
    .cap_data (mem_rdata),
    .st_vec   (VWriteData),
    .st_idx   (beat),
    .st_lane  (st_lane),
    .vec_out  (VReadData)
  );

  assign mem_addr  = issue ? (wa + ADDR_W'(beat)) : '0;
  assign mem_wdata = wdata;
  assign mem_we    = we;
  assign ReadData  = rdata_q;
  assign align_err = done & VecMem & (ALUresult[3:0] != 4'd0);

endmodule

// File: tb/tb_mem_stage_vlsu.sv
// Scoreboard bench for mem_stage_vlsu: stimulus pushes expected completions
// and memory writes into queues; a negedge monitor pops and compares.
module tb_mem_stage_vlsu;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int K_ST  = 0;
  localparam int K_LD  = 1;
  localparam int K_VST = 2;
  localparam int K_VLD = 3;

  typedef struct {
    int           kind;
    int           start;
    int           lat;
    logic         aerr;
    logic [31:0]  rd;
    logic [127:0] vrd;
  } exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              MemRead, MemWrite, VecMem;
  logic [31:0]       ALUresult, WriteData;
  logic [127:0]      VWriteData;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  logic [31:0]       ReadData;
  logic [127:0]      VReadData;
  logic              done, stall, align_err;

  logic [31:0] dmem    [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;

  mem_stage_vlsu #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .VecMem     (VecMem),
    .ALUresult  (ALUresult),
    .WriteData  (WriteData),
    .VWriteData (VWriteData),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .ReadData   (ReadData),
    .VReadData  (VReadData),
    .done       (done),
    .stall      (stall),
    .align_err  (align_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Synchronous data memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    mem_rdata <= dmem[mem_addr];
    if (mem_we) dmem[mem_addr] = mem_wdata;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Monitor: memory-write scoreboard, handshake checks, completion checks.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 1'b1, 1'b0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", 128'(mem_addr), 128'(w.addr));
          check("wr_data", 128'(mem_wdata), 128'(w.data));
        end
      end
      if (exp_q.size() != 0) begin
        check("stall", 128'(stall), 128'(!done));
        if (done) begin
          exp_t e;
          e = exp_q.pop_front();
          check("latency", 128'(cyc - e.start + 1), 128'(e.lat));
          check("align_err", 128'(align_err), 128'(e.aerr));
          if (e.kind == K_LD)  check("ReadData", 128'(ReadData), 128'(e.rd));
          if (e.kind == K_VLD) check("VReadData", VReadData, e.vrd);
        end
      end else begin
        check("idle_done", 128'(done), 128'(0));
        check("idle_stall", 128'(stall), 128'(0));
      end
    end
  end

  // Issue one access from the reference model's view, then wait for done.
  task automatic access(input bit rd, input bit wr, input bit vec,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [127:0] vwd);
    exp_t e;
    int unsigned wa;
    int n;
    wa      = (a >> 2) % DEPTH;
    e.start = cyc;
    e.aerr  = vec && ((a % 16) != 0);
    e.rd    = '0;
    e.vrd   = '0;
    if (wr) begin
      if (vec) begin
        e.kind = K_VST;
        e.lat  = 4;
        for (int k = 0; k < 4; k++) begin
          int unsigned ad;
          ad = (wa + k) % DEPTH;
          ref_mem[ad] = vwd[32*k +: 32];
          wr_q.push_back('{addr: ADDR_W'(ad), data: vwd[32*k +: 32]});
        end
      end else begin
        e.kind = K_ST;
        e.lat  = 1;
        ref_mem[wa] = wd;
        wr_q.push_back('{addr: ADDR_W'(wa), data: wd});
      end
    end else if (vec) begin
      e.kind = K_VLD;
      e.lat  = 6;
      for (int k = 0; k < 4; k++) e.vrd[32*k +: 32] = ref_mem[(wa + k) % DEPTH];
    end else begin
      e.kind = K_LD;
      e.lat  = 3;
      e.rd   = ref_mem[wa];
    end
    exp_q.push_back(e);

    MemRead    = rd;
    MemWrite   = wr;
    VecMem     = vec;
    ALUresult  = a;
    WriteData  = wd;
    VWriteData = vwd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    if (!done) begin
      check("done_timeout", 1'b0, 1'b1);
      finish_run();
    end
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      ALUresult  = $urandom;
      WriteData  = $urandom;
      VecMem     = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [127:0] v;
    logic [31:0]  a;
    int           op;

    for (int i = 0; i < DEPTH; i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    dmem[16]    = 32'd1234;
    ref_mem[16] = 32'd1234;

    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; VecMem = 1'b0;
    ALUresult = '0; WriteData = '0; VWriteData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_we", 128'(mem_we), 128'(0));
    check("rst_stall", 128'(stall), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ReadData", 128'(ReadData), 128'(0));
    check("rst_VReadData", VReadData, 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Directed cases.
    access(1, 0, 0, 32'h40, 0, 0);
    access(0, 1, 0, 32'h44, 32'd9999, 0);
    access(1, 0, 0, 32'h44, 0, 0);
    access(0, 1, 1, 32'h80, 0, {32'd4, 32'd3, 32'd2, 32'd1});
    idle_cycles(2);
    access(1, 0, 1, 32'h80, 0, 0);
    access(1, 0, 1, 32'((DEPTH - 2) * 4), 0, 0);
    access(1, 0, 1, 32'h84, 0, 0);
    access(1, 1, 1, 32'((DEPTH - 1) * 4 + 2), 0, {$urandom, $urandom, $urandom, $urandom});
    access(1, 0, 1, 32'((DEPTH - 1) * 4), 0, 0);

    // Randomised traffic, with occasional back-to-back accesses.
    for (int t = 0; t < 200; t++) begin
      op = $urandom_range(0, 3);
      a  = $urandom;
      if ($urandom_range(0, 3) == 0) a = a & ~32'hF;
      v  = {$urandom, $urandom, $urandom, $urandom};
      case (op)
        K_ST:    access(1'($urandom_range(0, 1)), 1, 0, a, $urandom, v);
        K_LD:    access(1, 0, 0, a, $urandom, v);
        K_VST:   access(1'($urandom_range(0, 1)), 1, 1, a, $urandom, v);
        default: access(1, 0, 1, a, $urandom, v);
      endcase
      idle_cycles($urandom_range(0, 2));
    end

    // Leave non-zero results registered before the reset test.
    access(1, 0, 0, 32'h40, 0, 0);
    access(1, 0, 1, 32'h80, 0, 0);

    // Reset in the middle of a vector store: only lane 0 reaches memory.
    mon_en = 1'b0;
    v = {$urandom, $urandom, $urandom, $urandom};
    ref_mem[32'h40] = v[31:0];
    MemWrite = 1'b1; VecMem = 1'b1; ALUresult = 32'h100; VWriteData = v;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mem_we", 128'(mem_we), 128'(0));
    check("midrst_done", 128'(done), 128'(0));
    check("midrst_stall", 128'(stall), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0; MemWrite = 1'b0; VecMem = 1'b0;
    @(negedge clk);
    check("postrst_mem_we", 128'(mem_we), 128'(0));
    check("postrst_stall", 128'(stall), 128'(0));
    check("postrst_mem_addr", 128'(mem_addr), 128'(0));
    check("postrst_mem_wdata", 128'(mem_wdata), 128'(0));
    check("postrst_ReadData", 128'(ReadData), 128'(0));
    check("postrst_VReadData", VReadData, 128'(0));
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check("postrst_mem_word", 128'(dmem[32'h40 + k]), 128'(ref_mem[32'h40 + k]));
    mon_en = 1'b1;
    access(1, 0, 1, 32'h100, 0, 0);
    idle_cycles(2);

    check("exp_q_empty", 128'(exp_q.size()), 128'(0));
    check("wr_q_empty", 128'(wr_q.size()), 128'(0));
    finish_run();
  end

endmodule
